// File: rtl/note_seq_recorder.sv
// note_seq_recorder: records timed note segments into a small buffer and replays them once or looped
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_note_in        live note code from the key mapper
//   i_note_valid     one-cycle pulse, i_note_in just changed
//   i_rec_start      one-cycle pulse, begin a fresh recording
//   i_play_start     one-cycle pulse, begin playback (ignored when buffer empty)
//   i_stop           one-cycle pulse, abort to idle (flushes a pending segment when recording)
//   i_loop_en        level, wrap playback to the first entry at the end of the buffer
//   o_note_out       registered note code for note_division / display
//   o_recording      recording in progress
//   o_playing        playback in progress
//   o_full           buffer holds DEPTH entries
//   o_count          number of stored entries
module note_seq_recorder #(
  parameter int NOTE_W = 4,
  parameter logic [NOTE_W-1:0] REST_CODE = NOTE_W'(15),
  parameter int DEPTH = 16,
  parameter int DUR_W = 8,
  parameter int TICK_DIV = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NOTE_W-1:0]          i_note_in,
  input  logic                       i_note_valid,
  input  logic                       i_rec_start,
  input  logic                       i_play_start,
  input  logic                       i_stop,
  input  logic                       i_loop_en,
  output logic [NOTE_W-1:0]          o_note_out,
  output logic                       o_recording,
  output logic                       o_playing,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [DUR_W-1:0] DMAX = '1;
  typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY} state_t;
  state_t r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [NOTE_W-1:0] r_cur, r_note_out;
  logic [DUR_W-1:0] r_dur, r_remain;
  logic [NOTE_W+DUR_W-1:0] r_mem [DEPTH];
  logic w_tick, w_wr_en, w_last;
  logic [PW-1:0] w_wr_ptr, w_nxt_ptr;
  logic [NOTE_W+DUR_W-1:0] w_wr_data, w_nxt_entry;
  always_comb begin
    w_tick = r_tick_cnt == TW'(TICK_DIV - 1);
    // stop flushes the pending segment; otherwise a note change closes it, or a
    // tick that would push dur to its maximum splits off a full-length segment
    w_wr_en = r_state == S_REC && r_count < CW'(DEPTH) &&
              (i_stop ? r_dur != '0 :
               !i_rec_start && (i_note_valid ? r_dur != '0 : w_tick && r_dur == DMAX - 1'b1));
    w_wr_data = {r_cur, (i_stop || i_note_valid) ? r_dur : DMAX};
    w_wr_ptr = PW'(r_count);
    w_last = CW'(r_rd_ptr) == r_count - 1'b1;
    w_nxt_ptr = w_last ? '0 : r_rd_ptr + 1'b1;
    w_nxt_entry = r_mem[w_nxt_ptr];
  end
  always_ff @(posedge clk)
    if (w_wr_en) r_mem[w_wr_ptr] <= w_wr_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tick_cnt <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_cur <= REST_CODE;
      r_dur <= '0;
      r_remain <= '0;
      r_note_out <= REST_CODE;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_wr_en) r_count <= r_count + 1'b1;
      if (i_stop) begin
        r_state <= S_IDLE;
        r_note_out <= REST_CODE;
      end else if (i_rec_start) begin
        r_state <= S_REC;
        r_count <= '0;
        r_cur <= REST_CODE;
        r_dur <= '0;
        r_tick_cnt <= '0;
        r_note_out <= REST_CODE;
      end else begin
        case (r_state)
          S_IDLE:
            if (i_play_start && r_count != '0) begin
              r_state <= S_PLAY;
              r_rd_ptr <= '0;
              r_tick_cnt <= '0;
              {r_note_out, r_remain} <= r_mem[0];
            end
          S_REC: begin
            if (i_note_valid) begin
              r_cur <= i_note_in;
              r_dur <= '0;
              r_note_out <= i_note_in;
            end else if (w_tick) r_dur <= (r_dur == DMAX - 1'b1) ? '0 : r_dur + 1'b1;
            // the write that fills the buffer ends the recording
            if (w_wr_en && r_count == CW'(DEPTH - 1)) begin
              r_state <= S_IDLE;
              r_note_out <= REST_CODE;
            end
          end
          S_PLAY:
            if (w_tick) begin
              if (r_remain == DUR_W'(1)) begin
                if (w_last && !i_loop_en) begin
                  r_state <= S_IDLE;
                  r_note_out <= REST_CODE;
                end else begin
                  r_rd_ptr <= w_nxt_ptr;
                  {r_note_out, r_remain} <= w_nxt_entry;
                end
              end else r_remain <= r_remain - 1'b1;
            end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
  assign o_note_out = r_note_out;
  assign o_recording = r_state == S_REC;
  assign o_playing = r_state == S_PLAY;
  assign o_full = r_count == CW'(DEPTH);
  assign o_count = r_count;
endmodule
